rom_sweep_checker: RTL and testbench
====================================

# rom_sweep_checker

Parametrised ROM sweep-and-verify engine for the display/overlay ROM path. On a start pulse it reads every address of an attached synchronous ROM once and checks each word against a selectable expectation: constant all-ones, address pattern, or whole-image checksum. It reports a saturating error count, the first failing address, the checksum and a pass flag. It serves as on-chip power-up self-test for initialised pattern ROMs and as the reusable checking core for their benches. Read latency, depth and width are parameters.

## Interface
- ADDR_WIDTH, 8, ROM address width; depth N = 2**ADDR_WIDTH
- DATA_WIDTH, 8, ROM data width
- RD_LATENCY, 1, cycles from address/rd_en to valid rom_rd_data; legal 1..3 (1 = unregistered output, 2 = output reg, 3 = output reg + OCE stage)
- ERR_CNT_WIDTH, 3, width of saturating error counter
- clk  in  1  clock; all logic on rising edge
- tb_rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; honoured only in IDLE
- mode  in  2  0 = all-ones compare, 1 = address pattern, 2 = checksum only, 3 = treated as 0; latched at start
- exp_sum  in  ADDR_WIDTH+DATA_WIDTH  expected checksum, used in mode 2; latched at start
- rom_addr  out  ADDR_WIDTH  ROM read address
- rom_rd_en  out  1  ROM read enable
- rom_rd_data  in  DATA_WIDTH  ROM read data
- busy  out  1  high from the cycle after accepted start through the done cycle
- done  out  1  one-cycle completion pulse
- pass  out  1  result of last sweep; held until next accepted start
- err_cnt  out  ERR_CNT_WIDTH  mismatch count, saturates at all-ones
- first_err_addr  out  ADDR_WIDTH  address of first mismatch of the sweep
- checksum  out  ADDR_WIDTH+DATA_WIDTH  sum of all words read, zero-extended

## Operation
- Reset value of every output is 0. FSM resets to IDLE.
- FSM states: IDLE, SWEEP, DRAIN, REPORT.
- IDLE: start=1 → SWEEP. On the same edge: clear err_cnt, checksum, first_err_addr and pass; latch mode and exp_sum; rom_addr=0; rom_rd_en=1.
- SWEEP: rom_rd_en=1 and rom_addr increments by 1 each cycle. After address N-1 is issued: go to DRAIN, rom_rd_en=0, rom_addr returns to 0. There is no wrap-around re-read.
- Valid/address tracking is a shift register of depth RD_LATENCY fed by rom_rd_en/rom_addr. Its output marks rom_rd_data as valid and carries the matching address.
- On each valid sample:
  - checksum += rom_rd_data (zero-extended; cannot overflow for N words).
  - Modes 0/3: mismatch if rom_rd_data != all-ones.
  - Mode 1: mismatch if rom_rd_data != address, zero-extended or truncated to DATA_WIDTH LSBs.
  - Mode 2: no per-word compare.
- On each mismatch: err_cnt increments, saturating at 2**ERR_CNT_WIDTH-1 with no wrap. If it is the sweep's first mismatch, first_err_addr captures the address.
- DRAIN: wait until the tracking pipe is empty, then go to REPORT.
- REPORT: done=1 for one cycle. pass = (err_cnt==0) in modes 0/1/3; pass = (checksum==exp_sum) in mode 2. Next state IDLE.
- start outside IDLE (including the REPORT cycle) is ignored and never queued.
- tb_rst asserted mid-sweep: immediate return to IDLE, all outputs 0, no done pulse, partial results discarded.

## Timing
- start sampled high at edge E0. rom_rd_en is high and rom_addr=k during cycle k (k=0..N-1 after E0).
- Data for address k is sampled at the end of cycle k+RD_LATENCY-1. The counters show the update in the following cycle.
- done is high in cycle N+RD_LATENCY; busy is high in cycles 0..N+RD_LATENCY.
- Total occupancy: N+RD_LATENCY+1 cycles. The next start is accepted from cycle N+RD_LATENCY+1.
- pass, err_cnt, first_err_addr and checksum are final and stable when done=1.

## Test plan
- AW=8, DW=8, L=1; ROM all 0xFF; mode 0 → done in cycle 257, err_cnt 0, pass 1, checksum 0xFF00.
- ROM word = address; mode 1 → pass 1, err_cnt 0, checksum 0x7F80. Same ROM in mode 0 → err_cnt 7 (saturated), first_err_addr 0x00, pass 0.
- All-0xFF ROM with 0x10 and 0x20 set to 0x00; mode 0 → err_cnt 2, first_err_addr 0x10, pass 0. With 10 corrupted words → err_cnt 7, no wrap.
- Mode 2, all-0xFF ROM: exp_sum 0xFF00 → pass 1. exp_sum 0xFEFF → pass 0 with err_cnt 0.
- RD_LATENCY=3, all-0xFF ROM, mode 0 → done in cycle 259, pass 1. Extra start pulses at cycles 5 and 259 are ignored; a start at cycle 260 begins a new sweep.
- tb_rst pulse while rom_addr=0x80 → all outputs 0 within the reset, no done. A following start completes normally with pass 1.

Source files
------------

// File: rtl/rom_sweep_checker.sv
// rtl/rom_sweep_checker.sv - ROM sweep-and-verify engine with selectable expectation
// Reads every ROM address once and checks each word against all-ones, address pattern or a whole-image checksum.
module rom_sweep_checker #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 3
) (
  input  logic                             clk,
  input  logic                             tb_rst,
  input  logic                             start,
  input  logic [1:0]                       mode,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] exp_sum,
  output logic [ADDR_WIDTH-1:0]            rom_addr,
  output logic                             rom_rd_en,
  input  logic [DATA_WIDTH-1:0]            rom_rd_data,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic [ERR_CNT_WIDTH-1:0]         err_cnt,
  output logic [ADDR_WIDTH-1:0]            first_err_addr,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] checksum
);

  localparam int SUM_WIDTH = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, REPORT} state_t;

  state_t                 state;
  logic [1:0]             mode_q;
  logic [SUM_WIDTH-1:0]   exp_sum_q;
  logic [RD_LATENCY-1:0]  vld_sr;
  logic [ADDR_WIDTH-1:0]  adr_sr [RD_LATENCY];
  logic                   issue_nxt;
  logic [ADDR_WIDTH-1:0]  addr_nxt;
  logic                   smp_vld;
  logic [ADDR_WIDTH-1:0]  smp_addr;
  logic                   mismatch;

  // Next read issue; the tracking pipe is loaded with the same value as rom_rd_en/rom_addr.
  always_comb begin
    issue_nxt = 1'b0;
    addr_nxt  = '0;
    if (state == IDLE && start) begin
      issue_nxt = 1'b1;
    end else if (state == SWEEP && rom_addr != '1) begin
      issue_nxt = 1'b1;
      addr_nxt  = rom_addr + ADDR_WIDTH'(1);
    end
  end

  assign smp_vld  = vld_sr[RD_LATENCY-1];
  assign smp_addr = adr_sr[RD_LATENCY-1];

  always_comb begin
    mismatch = 1'b0;
    if (smp_vld) begin
      case (mode_q)
        2'd1:    mismatch = (rom_rd_data != DATA_WIDTH'(smp_addr));
        2'd2:    mismatch = 1'b0;
        default: mismatch = (rom_rd_data != '1);
      endcase
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state          <= IDLE;
      mode_q         <= 2'd0;
      exp_sum_q      <= '0;
      rom_addr       <= '0;
      rom_rd_en      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      checksum       <= '0;
      vld_sr         <= '0;
      for (int i = 0; i < RD_LATENCY; i++) adr_sr[i] <= '0;
    end else begin
      rom_rd_en <= issue_nxt;
      rom_addr  <= addr_nxt;
      vld_sr[0] <= issue_nxt;
      adr_sr[0] <= addr_nxt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        adr_sr[i] <= adr_sr[i-1];
      end
      done <= 1'b0;

      if (smp_vld) begin
        checksum <= checksum + SUM_WIDTH'(rom_rd_data);
        if (mismatch) begin
          // err_cnt never wraps, so zero means this is the first mismatch of the sweep
          if (err_cnt == '0) first_err_addr <= smp_addr;
          if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state          <= SWEEP;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_cnt        <= '0;
            checksum       <= '0;
            first_err_addr <= '0;
            mode_q         <= mode;
            exp_sum_q      <= exp_sum;
          end
        end
        SWEEP: begin
          if (rom_addr == '1) state <= DRAIN;
        end
        DRAIN: begin
          if (vld_sr == '0) begin
            state <= REPORT;
            done  <= 1'b1;
            pass  <= (mode_q == 2'd2) ? (checksum == exp_sum_q) : (err_cnt == '0);
          end
        end
        REPORT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_sweep_checker.sv
// tb/tb_rom_sweep_checker.sv - checks rom_sweep_checker at read latency 1 and 3 against a sweep-level model
module tb_rom_sweep_checker;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int SW = AW + DW;
  localparam int N  = 256;

  logic                 clk = 1'b0;
  logic                 tb_rst;
  logic [1:0]           start;
  logic [1:0]           mode;
  logic [SW-1:0]        exp_sum;
  logic [1:0][AW-1:0]   rom_addr;
  logic [1:0]           rom_rd_en;
  logic [1:0][DW-1:0]   rom_rd_data;
  logic [1:0]           busy, done, pass;
  logic [1:0][2:0]      err_cnt;
  logic [1:0][AW-1:0]   first_err_addr;
  logic [1:0][SW-1:0]   checksum;

  logic [DW-1:0]        rom [N];
  logic [DW-1:0]        oreg3, oce3;

  int n_assert = 0;
  int n_fail   = 0;

  int m_cyc   [2] = '{-1, -1};
  int m_err   [2] = '{0, 0};
  int m_first [2] = '{0, 0};
  int m_sum   [2] = '{0, 0};
  int m_mode  [2] = '{0, 0};
  int m_exp   [2] = '{0, 0};
  bit m_pass  [2] = '{0, 0};

  always #5 clk = ~clk;

  rom_sweep_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .ERR_CNT_WIDTH(3)) dut1 (
    .clk(clk), .tb_rst(tb_rst), .start(start[0]), .mode(mode), .exp_sum(exp_sum),
    .rom_addr(rom_addr[0]), .rom_rd_en(rom_rd_en[0]), .rom_rd_data(rom_rd_data[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err_cnt[0]),
    .first_err_addr(first_err_addr[0]), .checksum(checksum[0]));

  rom_sweep_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3), .ERR_CNT_WIDTH(3)) dut3 (
    .clk(clk), .tb_rst(tb_rst), .start(start[1]), .mode(mode), .exp_sum(exp_sum),
    .rom_addr(rom_addr[1]), .rom_rd_en(rom_rd_en[1]), .rom_rd_data(rom_rd_data[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err_cnt[1]),
    .first_err_addr(first_err_addr[1]), .checksum(checksum[1]));

  // Latency 1: data follows the registered address; latency 3: output reg plus OCE stage.
  always @(posedge clk) begin
    oreg3 <= rom[rom_addr[1]];
    oce3  <= oreg3;
  end

  always_comb begin
    rom_rd_data[0] = rom[rom_addr[0]];
    rom_rd_data[1] = oce3;
  end

  task automatic chk(input string nm, input int i, input longint act, input longint exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  function automatic bit word_bad(input int md, input int a, input int w);
    if (md == 2) return 1'b0;
    if (md == 1) return w != (a & 255);
    return w != 255;
  endfunction

  function automatic int img_sum();
    int s = 0;
    for (int a = 0; a < N; a++) s += int'(rom[a]);
    return s;
  endfunction

  // Sweep-level model: cycle c of a sweep shows the results of words 0..c-L.
  always @(posedge clk or posedge tb_rst) begin
    for (int i = 0; i < 2; i++) begin
      int c, e, f, s, lat, k, w;
      bit p;
      lat = (i == 0) ? 1 : 3;
      c = m_cyc[i]; e = m_err[i]; f = m_first[i]; s = m_sum[i]; p = m_pass[i];
      if (tb_rst) begin
        c = -1; e = 0; f = 0; s = 0; p = 1'b0;
      end else if (c < 0) begin
        if (start[i]) begin
          c = 0; e = 0; f = 0; s = 0; p = 1'b0;
          m_mode[i] <= int'(mode);
          m_exp[i]  <= int'(exp_sum);
        end
      end else if (c == N + lat) begin
        c = -1;
      end else begin
        c++;
        k = c - lat;
        if (k >= 0 && k < N) begin
          w = int'(rom[8'(k)]);
          s += w;
          if (word_bad(m_mode[i], k, w)) begin
            if (e == 0) f = k;
            if (e < 7) e++;
          end
        end
        if (c == N + lat) p = (m_mode[i] == 2) ? (s == m_exp[i]) : (e == 0);
      end
      m_cyc[i] <= c; m_err[i] <= e; m_first[i] <= f; m_sum[i] <= s; m_pass[i] <= p;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int c, lat;
      bit en;
      lat = (i == 0) ? 1 : 3;
      c = m_cyc[i];
      en = (c >= 0 && c < N);
      chk("rom_rd_en", i, rom_rd_en[i], en);
      chk("rom_addr", i, rom_addr[i], en ? c : 0);
      chk("busy", i, busy[i], c >= 0);
      chk("done", i, done[i], c == N + lat);
      chk("err_cnt", i, err_cnt[i], m_err[i]);
      chk("first_err_addr", i, first_err_addr[i], m_first[i]);
      chk("checksum", i, checksum[i], m_sum[i]);
      chk("pass", i, pass[i], m_pass[i]);
    end
  end

  task automatic fill(input logic [DW-1:0] v);
    for (int a = 0; a < N; a++) rom[a] = v;
  endtask

  task automatic run(input logic [1:0] which, output int dc0, output int dc1);
    dc0 = -1;
    dc1 = -1;
    @(posedge clk); #1;
    start = which;
    @(posedge clk); #1;
    start = 2'b00;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (done[0] && dc0 < 0) dc0 = k;
      if (done[1] && dc1 < 0) dc1 = k;
      if ((!which[0] || dc0 >= 0) && (!which[1] || dc1 >= 0)) break;
      @(posedge clk); #1;
    end
    if (which[0]) chk("done_seen", 0, dc0 >= 0, 1);
    if (which[1]) chk("done_seen", 1, dc1 >= 0, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (busy == 2'b00) break;
    end
    chk("idle_reached", 0, busy, 0);
  endtask

  initial begin
    int d0, d1, dly, d3;
    tb_rst = 1'b1; start = 2'b00; mode = 2'd0; exp_sum = '0;
    fill(8'hFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 0, busy, 0);
    chk("reset_checksum", 0, checksum[0], 0);
    chk("reset_rd_en", 1, rom_rd_en, 0);
    #1 tb_rst = 1'b0;

    // all-ones image, mode 0
    mode = 2'd0;
    run(2'b11, d0, d1);
    chk("lit_done_cycle", 0, d0, 257);
    chk("lit_done_cycle", 1, d1, 259);
    chk("lit_err_cnt", 0, err_cnt[0], 0);
    chk("lit_pass", 0, pass[0], 1);
    chk("lit_checksum", 0, checksum[0], 16'hFF00);
    chk("lit_pass", 1, pass[1], 1);

    // address image in modes 1 and 0
    for (int a = 0; a < N; a++) rom[a] = 8'(a);
    mode = 2'd1;
    run(2'b11, d0, d1);
    chk("lit_pass_m1", 0, pass[0], 1);
    chk("lit_err_m1", 0, err_cnt[0], 0);
    chk("lit_checksum_m1", 0, checksum[0], 16'h7F80);
    mode = 2'd0;
    run(2'b11, d0, d1);
    chk("lit_err_sat", 0, err_cnt[0], 7);
    chk("lit_first_err", 0, first_err_addr[0], 0);
    chk("lit_pass_m0", 0, pass[0], 0);

    // two and ten corrupted words
    fill(8'hFF);
    rom[8'h10] = 8'h00; rom[8'h20] = 8'h00;
    run(2'b11, d0, d1);
    chk("lit_err_two", 0, err_cnt[0], 2);
    chk("lit_first_two", 0, first_err_addr[0], 8'h10);
    chk("lit_pass_two", 1, pass[1], 0);
    fill(8'hFF);
    for (int j = 0; j < 10; j++) rom[8'h40 + j] = 8'h5A;
    run(2'b11, d0, d1);
    chk("lit_err_ten", 0, err_cnt[0], 7);
    chk("lit_first_ten", 1, first_err_addr[1], 8'h40);

    // checksum mode
    fill(8'hFF);
    mode = 2'd2; exp_sum = 16'hFF00;
    run(2'b11, d0, d1);
    chk("lit_pass_sum", 0, pass[0], 1);
    exp_sum = 16'hFEFF;
    run(2'b11, d0, d1);
    chk("lit_fail_sum", 0, pass[0], 0);
    chk("lit_err_sum", 0, err_cnt[0], 0);

    // latency 3 with stray starts at cycles 5 and 259, accepted start at 260
    mode = 2'd0; exp_sum = '0;
    @(posedge clk); #1;
    start = 2'b10;
    @(posedge clk); #1;
    start = 2'b00;
    d3 = -1;
    for (int k = 0; k < 263; k++) begin
      start[1] = (k == 5 || k == 259 || k == 260);
      @(negedge clk);
      if (done[1] && d3 < 0) d3 = k;
      if (k == 260) chk("lit_idle_260", 1, busy[1], 0);
      if (k == 261) chk("lit_busy_261", 1, busy[1], 1);
      @(posedge clk); #1;
    end
    start = 2'b00;
    chk("lit_done_l3", 1, d3, 259);
    wait_idle();

    // reset in mid-sweep
    @(posedge clk); #1;
    start = 2'b11;
    @(posedge clk); #1;
    start = 2'b00;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (rom_addr[0] == 8'h80) break;
    end
    chk("lit_addr_80", 0, rom_addr[0], 8'h80);
    #1 tb_rst = 1'b1;
    @(posedge clk); #1;
    chk("lit_rst_busy", 0, busy, 0);
    chk("lit_rst_done", 0, done, 0);
    chk("lit_rst_addr", 0, rom_addr, 0);
    chk("lit_rst_sum", 1, checksum[1], 0);
    @(posedge clk); #1;
    tb_rst = 1'b0;
    run(2'b11, d0, d1);
    chk("lit_pass_after_rst", 0, pass[0], 1);
    chk("lit_pass_after_rst", 1, pass[1], 1);

    // randomized images, modes, staggered starts and stray start pulses
    for (int it = 0; it < 8; it++) begin
      int kind;
      kind = $urandom_range(0, 2);
      for (int a = 0; a < N; a++)
        rom[a] = (kind == 0) ? 8'hFF : (kind == 1) ? 8'(a) : 8'($urandom);
      for (int j = $urandom_range(0, 12); j > 0; j--) rom[8'($urandom)] = 8'($urandom);
      mode = 2'($urandom_range(0, 3));
      exp_sum = ($urandom_range(0, 1) == 1) ? 16'(img_sum()) : 16'($urandom);
      @(posedge clk); #1;
      start = 2'b01;
      @(posedge clk); #1;
      start = 2'b00;
      dly = $urandom_range(0, 30);
      repeat (dly) begin @(posedge clk); #1; end
      start = 2'b10;
      @(posedge clk); #1;
      start = 2'b00;
      for (int k = 0; k < 800; k++) begin
        if (busy == 2'b00) break;
        start = {busy[1] & ($urandom_range(0, 7) == 0), busy[0] & ($urandom_range(0, 7) == 0)};
        @(posedge clk); #1;
      end
      start = 2'b00;
      chk("rand_idle", it, busy, 0);
    end

    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
